// File: rtl/zero_strip_serializer.sv
// Wide-to-narrow serializer: emits a word LSB chunk first and, optionally, stops
// after the highest non-zero chunk so the receiver can zero-fill the rest.
module zero_strip_serializer #(
  parameter int WIDE_WIDTH      = 8,
  parameter int NARROW_WIDTH    = 4,
  parameter bit SKIP_ZERO_UPPER = 1'b1,
  localparam int NUM_BEATS      = WIDE_WIDTH / NARROW_WIDTH,
  localparam int IDXW           = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [WIDE_WIDTH-1:0]   Data_In,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [NARROW_WIDTH-1:0] Data_Out,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Out_Last,
  output logic [IDXW-1:0]         Beat_Idx
);

  generate
    if ((WIDE_WIDTH % NARROW_WIDTH) != 0 || WIDE_WIDTH <= NARROW_WIDTH) begin : g_bad_params
      $error("zero_strip_serializer: WIDE_WIDTH must be a multiple of and larger than NARROW_WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [WIDE_WIDTH-1:0]   word_reg, word_next;
  logic [IDXW-1:0]         beat_idx_reg, beat_idx_next;
  logic [IDXW-1:0]         last_idx_reg, last_idx_next;

  logic [NARROW_WIDTH-1:0] in_chunk   [NUM_BEATS];
  logic [NARROW_WIDTH-1:0] word_chunk [NUM_BEATS];
  logic [NUM_BEATS-1:0]    in_chunk_nz;
  logic [IDXW-1:0]         last_idx_in;

  logic out_valid;
  logic out_last;
  logic in_ready;
  logic in_fire;
  logic beat_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BEATS; gi++) begin : g_chunk
      assign in_chunk[gi]    = Data_In[gi*NARROW_WIDTH +: NARROW_WIDTH];
      assign word_chunk[gi]  = word_reg[gi*NARROW_WIDTH +: NARROW_WIDTH];
      assign in_chunk_nz[gi] = |in_chunk[gi];
    end
  endgenerate

  // Index of the final beat for the incoming word; an all-zero word still sends chunk 0.
  always_comb begin
    last_idx_in = SKIP_ZERO_UPPER ? '0 : IDXW'(NUM_BEATS - 1);
    if (SKIP_ZERO_UPPER) begin
      for (int i = 0; i < NUM_BEATS; i++) begin
        if (in_chunk_nz[i]) last_idx_in = IDXW'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      beat_idx_reg <= '0;
      last_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      beat_idx_reg <= beat_idx_next;
      last_idx_reg <= last_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    beat_idx_next = beat_idx_reg;
    last_idx_next = last_idx_reg;

    out_valid = (state_reg == SEND);
    out_last  = out_valid && (beat_idx_reg == last_idx_reg);
    beat_fire = out_valid && Out_Ready;
    // Accepting on the last-beat edge lets words stream back to back without a bubble.
    in_ready  = (state_reg == IDLE) || (out_last && Out_Ready);
    in_fire   = In_Valid && in_ready;

    if (in_fire) begin
      state_next    = SEND;
      word_next     = Data_In;
      beat_idx_next = '0;
      last_idx_next = last_idx_in;
    end else if (beat_fire) begin
      if (out_last) begin
        state_next    = IDLE;
        beat_idx_next = '0;
      end else begin
        beat_idx_next = beat_idx_reg + 1'b1;
      end
    end
  end

  assign In_Ready  = in_ready;
  assign Out_Valid = out_valid;
  assign Out_Last  = out_last;
  assign Beat_Idx  = beat_idx_reg;
  assign Data_Out  = out_valid ? word_chunk[beat_idx_reg] : '0;

endmodule

// File: tb/tb_zero_strip_serializer.sv
// Bench for zero_strip_serializer: three configurations checked every cycle
// against a queue of expected beats derived from each accepted word.
module tb_zero_strip_serializer;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic        inv  [3];
  logic        ordy [3];
  logic [15:0] word [3];

  logic       inr0, ov0, ol0;
  logic [3:0] do0;
  logic [0:0] bi0;
  logic       inr1, ov1, ol1;
  logic [3:0] do1;
  logic [0:0] bi1;
  logic       inr2, ov2, ol2;
  logic [3:0] do2;
  logic [1:0] bi2;
  logic [7:0]  din0, din1;
  logic [15:0] din2;

  assign din0 = word[0][7:0];
  assign din1 = word[1][7:0];
  assign din2 = word[2];

  zero_strip_serializer #(.WIDE_WIDTH(8), .NARROW_WIDTH(4), .SKIP_ZERO_UPPER(1'b1)) dut0 (
    .Clk(Clk), .Reset(Reset), .Data_In(din0), .In_Valid(inv[0]), .In_Ready(inr0),
    .Data_Out(do0), .Out_Valid(ov0), .Out_Ready(ordy[0]), .Out_Last(ol0), .Beat_Idx(bi0));

  zero_strip_serializer #(.WIDE_WIDTH(8), .NARROW_WIDTH(4), .SKIP_ZERO_UPPER(1'b0)) dut1 (
    .Clk(Clk), .Reset(Reset), .Data_In(din1), .In_Valid(inv[1]), .In_Ready(inr1),
    .Data_Out(do1), .Out_Valid(ov1), .Out_Ready(ordy[1]), .Out_Last(ol1), .Beat_Idx(bi1));

  zero_strip_serializer #(.WIDE_WIDTH(16), .NARROW_WIDTH(4), .SKIP_ZERO_UPPER(1'b1)) dut2 (
    .Clk(Clk), .Reset(Reset), .Data_In(din2), .In_Valid(inv[2]), .In_Ready(inr2),
    .Data_Out(do2), .Out_Valid(ov2), .Out_Ready(ordy[2]), .Out_Last(ol2), .Beat_Idx(bi2));

  typedef struct {
    int         cfg;
    logic [3:0] data;
    logic       last;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int wide_of(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic bit skip_of(input int k);
    return (k != 1);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int find_front(input int k);
    for (int i = 0; i < q.size(); i++) if (q[i].cfg == k) return i;
    return -1;
  endfunction

  function automatic int pending(input int k);
    int n = 0;
    for (int i = 0; i < q.size(); i++) if (q[i].cfg == k) n++;
    return n;
  endfunction

  // Reference: chunks 0..last go out in order; last is the top non-zero chunk when skipping.
  function automatic void push_word(input int k, input logic [15:0] w);
    int nb = wide_of(k) / 4;
    int last = skip_of(k) ? 0 : nb - 1;
    logic [15:0] tmp;
    exp_t e;
    if (skip_of(k)) begin
      for (int i = 0; i < nb; i++) begin
        tmp = w >> (4 * i);
        if (tmp[3:0] != 4'h0) last = i;
      end
    end
    for (int i = 0; i <= last; i++) begin
      tmp    = w >> (4 * i);
      e.cfg  = k;
      e.data = tmp[3:0];
      e.last = (i == last);
      e.idx  = i;
      q.push_back(e);
    end
  endfunction

  task automatic get_out(input int k, output logic ir, output logic ov, output logic ol,
                         output logic [3:0] d, output int idx);
    case (k)
      0:       begin ir = inr0; ov = ov0; ol = ol0; d = do0; idx = int'(bi0); end
      1:       begin ir = inr1; ov = ov1; ol = ol1; d = do1; idx = int'(bi1); end
      default: begin ir = inr2; ov = ov2; ol = ol2; d = do2; idx = int'(bi2); end
    endcase
  endtask

  // Called just after a falling edge with inputs driven; checks, then advances one clock.
  task automatic step();
    logic ir, ov, ol;
    logic [3:0] d;
    int idx, f;
    bit exp_ir, exp_ov;
    bit in_acc [3];
    bit out_acc [3];
    #1;
    for (int k = 0; k < 3; k++) begin
      get_out(k, ir, ov, ol, d, idx);
      f      = find_front(k);
      exp_ov = (f >= 0);
      exp_ir = (pending(k) == 0) || (pending(k) == 1 && ordy[k]);
      check_val($sformatf("cfg%0d out_valid", k), 32'(ov), 32'(exp_ov));
      check_val($sformatf("cfg%0d in_ready", k), 32'(ir), 32'(exp_ir));
      if (f >= 0) begin
        check_val($sformatf("cfg%0d data_out", k), 32'(d), 32'(q[f].data));
        check_val($sformatf("cfg%0d out_last", k), 32'(ol), 32'(q[f].last));
        check_val($sformatf("cfg%0d beat_idx", k), 32'(idx), 32'(q[f].idx));
      end
      in_acc[k]  = inv[k] && exp_ir;
      out_acc[k] = exp_ov && ordy[k];
    end
    if (Reset) begin
      q.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (out_acc[k]) begin
          f = find_front(k);
          $display("cfg%0d beat idx=%0d data=%h last=%b", k, q[f].idx, q[f].data, q[f].last);
          q.delete(f);
        end
        if (in_acc[k]) push_word(k, word[k]);
      end
    end
    @(negedge Clk);
  endtask

  task automatic post_reset_check();
    logic ir, ov, ol;
    logic [3:0] d;
    int idx;
    #1;
    for (int k = 0; k < 3; k++) begin
      get_out(k, ir, ov, ol, d, idx);
      check_val($sformatf("cfg%0d rst data_out", k), 32'(d), 32'h0);
      check_val($sformatf("cfg%0d rst beat_idx", k), 32'(idx), 32'h0);
      check_val($sformatf("cfg%0d rst out_last", k), 32'(ol), 32'h0);
    end
  endtask

  task automatic quiet();
    for (int k = 0; k < 3; k++) begin
      inv[k]  = 1'b0;
      ordy[k] = 1'b1;
      word[k] = 16'h0;
    end
  endtask

  task automatic send(input int k, input logic [15:0] w, input int drain);
    word[k] = w;
    inv[k]  = 1'b1;
    step();
    inv[k]  = 1'b0;
    for (int i = 0; i < drain; i++) step();
  endtask

  initial begin
    logic [31:0] r;
    quiet();
    Reset = 1'b1;
    @(negedge Clk);
    step();
    step();
    Reset = 1'b0;
    post_reset_check();

    // Reset in the middle of a stalled 8'hA5 word.
    ordy[0] = 1'b0;
    send(0, 16'h00A5, 1);
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    post_reset_check();
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) step();

    send(0, 16'h00A5, 3);
    send(0, 16'h0005, 2);
    send(0, 16'h0000, 2);

    ordy[0] = 1'b0;
    send(0, 16'h003C, 2);
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) step();

    send(1, 16'h0005, 3);
    send(2, 16'h0120, 4);

    // Held In_Valid: A5 then 5A stream with no bubble.
    word[0] = 16'h00A5;
    inv[0]  = 1'b1;
    step();
    word[0] = 16'h005A;
    step();
    step();
    inv[0]  = 1'b0;
    for (int i = 0; i < 3; i++) step();

    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 249) == 0);
      for (int k = 0; k < 3; k++) begin
        inv[k]  = $urandom_range(0, 1);
        ordy[k] = ($urandom_range(0, 3) != 0);
        r       = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) r = 32'h0;
        word[k] = (k == 2) ? r[15:0] : {8'h00, r[7:0]};
      end
      step();
    end
    Reset = 1'b0;
    quiet();
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
